// File: rtl/wbck_arbiter.sv
// Write-back arbiter for the single register-file write port (LSU, mul/div, ALU),
// plus a scoreboard of destination registers with long-latency results outstanding.
module wbck_arbiter #(
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_idx,
  input  logic [31:0] alu_dat,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [4:0]  lsu_idx,
  input  logic [31:0] lsu_dat,
  input  logic        lng_valid,
  output logic        lng_ready,
  input  logic [4:0]  lng_idx,
  input  logic [31:0] lng_dat,
  input  logic        disp_valid,
  input  logic [4:0]  disp_idx,
  output logic        disp_ready,
  input  logic [4:0]  src1_idx,
  input  logic [4:0]  src2_idx,
  output logic        src1_hzd,
  output logic        src2_hzd,
  output logic [31:0] pend_vec,
  output logic        wbck_dest_wen,
  output logic [4:0]  wbck_dest_idx,
  output logic [31:0] wbck_dest_dat
);

  localparam logic [3:0] STV_LIM = 4'(STARVE_LIM);

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_LSU  = 2'd1,
    SEL_LNG  = 2'd2,
    SEL_ALU  = 2'd3
  } sel_e;

  sel_e        sel_s;
  logic        alu_first_s;
  logic [4:0]  gnt_idx_s;
  logic [31:0] gnt_dat_s;

  logic [3:0]  stv_q, stv_d;
  logic [31:0] pend_q, pend_d;
  logic        wen_q, wen_d;
  logic [4:0]  idx_q, idx_d;
  logic [31:0] dat_q, dat_d;

  assign alu_first_s = (stv_q == STV_LIM);

  // Priority select; a starved ALU jumps to the front for one cycle.
  always_comb begin
    sel_s = SEL_NONE;
    if (alu_first_s && alu_valid) begin
      sel_s = SEL_ALU;
    end else if (lsu_valid) begin
      sel_s = SEL_LSU;
    end else if (lng_valid) begin
      sel_s = SEL_LNG;
    end else if (alu_valid) begin
      sel_s = SEL_ALU;
    end else begin
      sel_s = SEL_NONE;
    end
  end

  assign lsu_ready = (sel_s == SEL_LSU);
  assign lng_ready = (sel_s == SEL_LNG);
  assign alu_ready = (sel_s == SEL_ALU);

  // Write-port payload of the granted producer.
  always_comb begin
    gnt_idx_s = 5'd0;
    gnt_dat_s = 32'd0;
    case (sel_s)
      SEL_LSU: begin
        gnt_idx_s = lsu_idx;
        gnt_dat_s = lsu_dat;
      end
      SEL_LNG: begin
        gnt_idx_s = lng_idx;
        gnt_dat_s = lng_dat;
      end
      SEL_ALU: begin
        gnt_idx_s = alu_idx;
        gnt_dat_s = alu_dat;
      end
      default: begin
        gnt_idx_s = 5'd0;
        gnt_dat_s = 32'd0;
      end
    endcase
  end

  // Starvation counter: counts consecutive denied ALU cycles, saturating.
  always_comb begin
    stv_d = stv_q;
    if (!alu_valid || (sel_s == SEL_ALU)) begin
      stv_d = 4'd0;
    end else if (stv_q < STV_LIM) begin
      stv_d = stv_q + 4'd1;
    end else begin
      stv_d = stv_q;
    end
  end

  // Output stage next state; x0 grants consume the producer but never write.
  always_comb begin
    wen_d = 1'b0;
    idx_d = idx_q;
    dat_d = dat_q;
    if (sel_s != SEL_NONE) begin
      wen_d = (gnt_idx_s != 5'd0);
      idx_d = gnt_idx_s;
      dat_d = gnt_dat_s;
    end else begin
      wen_d = 1'b0;
    end
  end

  // Scoreboard: clear on the register-file write, then set on dispatch so a collision stays pending.
  always_comb begin
    pend_d = pend_q;
    if (wen_q) begin
      pend_d[idx_q] = 1'b0;
    end else begin
      pend_d = pend_q;
    end
    if (disp_valid && disp_ready && (disp_idx != 5'd0)) begin
      pend_d[disp_idx] = 1'b1;
    end else begin
      pend_d[0] = 1'b0;
    end
    pend_d[0] = 1'b0;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stv_q  <= 4'd0;
      pend_q <= 32'd0;
      wen_q  <= 1'b0;
      idx_q  <= 5'd0;
      dat_q  <= 32'd0;
    end else begin
      stv_q  <= stv_d;
      pend_q <= pend_d;
      wen_q  <= wen_d;
      idx_q  <= idx_d;
      dat_q  <= dat_d;
    end
  end

  assign disp_ready    = (disp_idx == 5'd0) ? 1'b1 : ~pend_q[disp_idx];
  assign src1_hzd      = (src1_idx != 5'd0) & pend_q[src1_idx];
  assign src2_hzd      = (src2_idx != 5'd0) & pend_q[src2_idx];
  assign pend_vec      = pend_q;
  assign wbck_dest_wen = wen_q;
  assign wbck_dest_idx = idx_q;
  assign wbck_dest_dat = dat_q;

endmodule

// File: tb/tb_wbck_arbiter.sv
// Bench for wbck_arbiter: directed scenarios plus randomized traffic, all checked
// each cycle against a transaction-level model of grants, write-backs and pending registers.
module tb_wbck_arbiter;

  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, alu_ready, lsu_valid, lsu_ready, lng_valid, lng_ready;
  logic [4:0]  alu_idx, lsu_idx, lng_idx, disp_idx, src1_idx, src2_idx;
  logic [31:0] alu_dat, lsu_dat, lng_dat;
  logic        disp_valid, disp_ready, src1_hzd, src2_hzd;
  logic [31:0] pend_vec;
  logic        wbck_dest_wen;
  logic [4:0]  wbck_dest_idx;
  logic [31:0] wbck_dest_dat;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] m_pend;
  int          m_stv;
  logic        m_wen;
  logic [4:0]  m_idx;
  logic [31:0] m_dat;
  bit          m_known;

  wbck_arbiter #(.STARVE_LIM(LIM)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_idx(alu_idx), .alu_dat(alu_dat),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_idx(lsu_idx), .lsu_dat(lsu_dat),
    .lng_valid(lng_valid), .lng_ready(lng_ready), .lng_idx(lng_idx), .lng_dat(lng_dat),
    .disp_valid(disp_valid), .disp_idx(disp_idx), .disp_ready(disp_ready),
    .src1_idx(src1_idx), .src2_idx(src2_idx), .src1_hzd(src1_hzd), .src2_hzd(src2_hzd),
    .pend_vec(pend_vec),
    .wbck_dest_wen(wbck_dest_wen), .wbck_dest_idx(wbck_dest_idx), .wbck_dest_dat(wbck_dest_dat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Producer numbering: 0 = LSU, 1 = LNG, 2 = ALU.
  function automatic int pick(input bit [2:0] v, input bit alu_first);
    int order[3];
    if (alu_first) order = '{2, 0, 1};
    else           order = '{0, 1, 2};
    for (int k = 0; k < 3; k++) if (v[order[k]]) return order[k];
    return -1;
  endfunction

  function automatic bit pending(input logic [4:0] i);
    return (i != 5'd0) && m_pend[i];
  endfunction

  // Checks one cycle at negedge+1, advances the model, then retires granted producers.
  task automatic tick();
    int          w;
    bit          exp_dr;
    logic [4:0]  gi;
    logic [31:0] gd;
    #1;
    w = pick({alu_valid, lng_valid, lsu_valid}, m_stv >= LIM);
    exp_dr = (disp_idx == 5'd0) || !m_pend[disp_idx];
    chk("lsu_ready", 32'(lsu_ready), 32'(w == 0));
    chk("lng_ready", 32'(lng_ready), 32'(w == 1));
    chk("alu_ready", 32'(alu_ready), 32'(w == 2));
    chk("disp_ready", 32'(disp_ready), 32'(exp_dr));
    chk("src1_hzd", 32'(src1_hzd), 32'(pending(src1_idx)));
    chk("src2_hzd", 32'(src2_hzd), 32'(pending(src2_idx)));
    chk("pend_vec", pend_vec, m_pend);
    chk("wen", 32'(wbck_dest_wen), 32'(m_wen));
    if (m_known) begin
      chk("wb_idx", 32'(wbck_dest_idx), 32'(m_idx));
      chk("wb_dat", wbck_dest_dat, m_dat);
    end
    if (rst) begin
      m_pend = 32'd0; m_stv = 0; m_wen = 1'b0; m_idx = 5'd0; m_dat = 32'd0; m_known = 1'b1;
    end else begin
      if (m_wen) m_pend[m_idx] = 1'b0;
      if (disp_valid && exp_dr && disp_idx != 5'd0) m_pend[disp_idx] = 1'b1;
      if (alu_valid && w != 2) m_stv = (m_stv < LIM) ? m_stv + 1 : m_stv;
      else m_stv = 0;
      gi = (w == 0) ? lsu_idx : (w == 1) ? lng_idx : alu_idx;
      gd = (w == 0) ? lsu_dat : (w == 1) ? lng_dat : alu_dat;
      if (w >= 0) begin
        m_wen = (gi != 5'd0); m_idx = gi; m_dat = gd; m_known = (gi != 5'd0);
      end else begin
        m_wen = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    if (w == 0) lsu_valid = 1'b0;
    if (w == 1) lng_valid = 1'b0;
    if (w == 2) alu_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; lsu_valid = 1'b0; lng_valid = 1'b0; disp_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    alu_idx = 5'd0; lsu_idx = 5'd0; lng_idx = 5'd0; disp_idx = 5'd0;
    alu_dat = 32'd0; lsu_dat = 32'd0; lng_dat = 32'd0;
    src1_idx = 5'd0; src2_idx = 5'd0;
    @(posedge clk);
    @(negedge clk);
    m_pend = 32'd0; m_stv = 0; m_wen = 1'b0; m_idx = 5'd0; m_dat = 32'd0; m_known = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_wen", 32'(wbck_dest_wen), 32'd0);
    chk("rst_pend", pend_vec, 32'd0);
    chk("rst_idx", 32'(wbck_dest_idx), 32'd0);

    // All three producers at once: LSU, LNG, ALU in turn.
    lsu_valid = 1'b1; lsu_idx = 5'd5; lsu_dat = 32'hAAAA0001;
    lng_valid = 1'b1; lng_idx = 5'd6; lng_dat = 32'hBBBB0002;
    alu_valid = 1'b1; alu_idx = 5'd7; alu_dat = 32'hCCCC0003;
    tick();
    chk("t1_c1_wen", 32'(wbck_dest_wen), 32'd1);
    chk("t1_c1_idx", 32'(wbck_dest_idx), 32'd5);
    tick();
    chk("t1_c2_idx", 32'(wbck_dest_idx), 32'd6);
    chk("t1_c2_dat", wbck_dest_dat, 32'hBBBB0002);
    tick();
    chk("t1_c3_idx", 32'(wbck_dest_idx), 32'd7);
    chk("t1_c3_dat", wbck_dest_dat, 32'hCCCC0003);
    tick();
    chk("t1_c4_wen", 32'(wbck_dest_wen), 32'd0);
    chk("t1_c4_hold", 32'(wbck_dest_idx), 32'd7);

    // Starvation: LSU always valid, ALU forced through in cycle 4.
    alu_valid = 1'b1; alu_idx = 5'd7; alu_dat = 32'h0000A1A1;
    for (int c = 0; c < 5; c++) begin
      lsu_valid = 1'b1; lsu_idx = 5'd8; lsu_dat = 32'(c);
      if (c == 4) begin
        #1;
        chk("stv_alu_rdy", 32'(alu_ready), 32'd1);
        chk("stv_lsu_rdy", 32'(lsu_ready), 32'd0);
      end else begin
        #1;
        chk("stv_deny", 32'(alu_ready), 32'd0);
      end
      tick();
    end
    alu_valid = 1'b1; alu_dat = 32'h0000A2A2;
    #1;
    chk("stv_cleared", 32'(lsu_ready), 32'd1);
    tick();
    idle_inputs();
    tick();

    // Scoreboard: dispatch x9, hazard until the LNG write lands.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    disp_valid = 1'b1; disp_idx = 5'd9;
    tick();
    disp_valid = 1'b0; src1_idx = 5'd9;
    #1;
    chk("sb_hzd", 32'(src1_hzd), 32'd1);
    chk("sb_waw", 32'(disp_ready), 32'd0);
    tick();
    tick();
    lng_valid = 1'b1; lng_idx = 5'd9; lng_dat = 32'h12345678;
    tick();
    chk("sb_wen", 32'(wbck_dest_wen), 32'd1);
    chk("sb_hzd_c4", 32'(src1_hzd), 32'd1);
    tick();
    chk("sb_hzd_c5", 32'(src1_hzd), 32'd0);

    // Write-back to x0: consumed, never written.
    alu_valid = 1'b1; alu_idx = 5'd0; alu_dat = 32'hDEADBEEF;
    #1;
    chk("x0_ready", 32'(alu_ready), 32'd1);
    tick();
    chk("x0_wen", 32'(wbck_dest_wen), 32'd0);
    chk("x0_pend", pend_vec, m_pend);

    // Dispatch colliding with a write-back to the same index: set wins.
    alu_valid = 1'b1; alu_idx = 5'd12; alu_dat = 32'h0C0C0C0C;
    tick();
    disp_valid = 1'b1; disp_idx = 5'd12;
    tick();
    disp_valid = 1'b0;
    chk("set_wins", 32'(pend_vec[12]), 32'd1);

    // Reset one cycle after dispatch/grant of x3.
    disp_valid = 1'b1; disp_idx = 5'd3;
    lsu_valid = 1'b1; lsu_idx = 5'd3; lsu_dat = 32'h33333333;
    tick();
    disp_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_pend", pend_vec, 32'd0);
    chk("mrst_wen", 32'(wbck_dest_wen), 32'd0);
    tick();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      if (!lsu_valid && $urandom_range(1, 0) == 1) begin
        lsu_valid = 1'b1; lsu_idx = 5'($urandom); lsu_dat = $urandom;
      end
      if (!lng_valid && $urandom_range(1, 0) == 1) begin
        lng_valid = 1'b1; lng_idx = 5'($urandom); lng_dat = $urandom;
      end
      if (!alu_valid && $urandom_range(2, 0) != 0) begin
        alu_valid = 1'b1;
        alu_idx = ($urandom_range(7, 0) == 0) ? 5'd0 : 5'($urandom);
        alu_dat = $urandom;
      end
      disp_valid = ($urandom_range(2, 0) == 0);
      disp_idx = 5'($urandom);
      src1_idx = 5'($urandom);
      src2_idx = 5'($urandom);
      rst = ($urandom_range(63, 0) == 0);
      tick();
    end
    rst = 1'b0;
    idle_inputs();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
